// File: rtl/uart_fifoed_recv.sv
// 8N1 UART receiver feeding a circular receive FIFO. A byte appears in the FIFO
// one cycle after its mid-stop-bit sample, and is popped with dat_rd (registered response).
module uart_fifoed_recv #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 128,
    parameter int AFULL_LEVEL  = 122
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       RX,
    input  logic       dat_rd,
    output logic [7:0] dat,
    output logic       dat_valid,
    output logic       fifo_empty,
    output logic       fifo_afull,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [11:0] CNT_HALF  = 12'(CLKS_PER_BIT / 2 - 1);
    localparam logic [11:0] CNT_BIT   = 12'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] OCC_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] OCC_AFULL = (AW + 1)'(AFULL_LEVEL);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
    logic [11:0]     cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [AW-1:0]   wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [AW:0]     occ_q, occ_d;
    logic [7:0]      dat_q, dat_d;
    logic            dat_valid_q, dat_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;
    logic            byte_ok, push, pop;
    logic [7:0]      mem [FIFO_DEPTH];

    always_comb begin
        sync1_d     = RX;
        rxs_d       = sync1_q;
        rxs_prev_d  = rxs_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_ok     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d     = CNT_BIT;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end
                end else begin
                    cnt_d = cnt_q - 12'd1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    cnt_d     = CNT_BIT;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7)
                        state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 12'd1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    // Leaving at mid-stop lets a start bit right behind it be caught.
                    state_d     = IDLE;
                    byte_ok     = rxs_q;
                    frame_err_d = !rxs_q;
                end else begin
                    cnt_d = cnt_q - 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A full FIFO drops the byte even if a pop frees a slot this cycle.
        push        = byte_ok && (occ_q != OCC_FULL);
        overflow_d  = byte_ok && (occ_q == OCC_FULL);
        pop         = dat_rd && (occ_q != '0);

        wr_idx_d    = push ? wr_idx_q + 1'b1 : wr_idx_q;
        rd_idx_d    = pop  ? rd_idx_q + 1'b1 : rd_idx_q;
        dat_d       = pop  ? mem[rd_idx_q] : dat_q;
        dat_valid_d = pop;

        occ_d = occ_q;
        if (push && !pop)
            occ_d = occ_q + 1'b1;
        else if (pop && !push)
            occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            occ_q       <= '0;
            dat_q       <= '0;
            dat_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            rxs_prev_q  <= rxs_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            occ_q       <= occ_d;
            dat_q       <= dat_d;
            dat_valid_q <= dat_valid_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is never cleared; stale entries are unreachable once indices reset.
    always_ff @(posedge clk_100MHz) begin
        if (push)
            mem[wr_idx_q] <= shift_q;
    end

    assign dat        = dat_q;
    assign dat_valid  = dat_valid_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign fifo_empty = (occ_q == '0);
    assign fifo_afull = (occ_q >= OCC_AFULL);
    assign fifo_full  = (occ_q == OCC_FULL);
endmodule

// File: tb/tb_uart_fifoed_recv.sv
// Bench for uart_fifoed_recv: directed frames plus a random fill, against a byte-queue model.
// The bit period is shortened so that the 129-frame fill stays short; timings scale with CPB.
module tb_uart_fifoed_recv;
    localparam int CPB   = 32;
    localparam int DEPTH = 128;
    localparam int AFULL = 122;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       RX         = 1'b1;
    logic       dat_rd     = 1'b0;
    logic [7:0] dat;
    logic       dat_valid, fifo_empty, fifo_afull, fifo_full, frame_err, overflow;

    uart_fifoed_recv #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .RX        (RX),
        .dat_rd    (dat_rd),
        .dat       (dat),
        .dat_valid (dat_valid),
        .fifo_empty(fifo_empty),
        .fifo_afull(fifo_afull),
        .fifo_full (fifo_full),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   fall_cyc = -1;
    logic empty_prev = 1'b1;
    logic [7:0] model_q [$];
    int   exp_ov = 0;

    always @(posedge clk_100MHz) cyc++;

    always @(negedge clk_100MHz) begin
        if (frame_err) fe_cnt++;
        if (overflow) ov_cnt++;
        if (empty_prev && !fifo_empty) fall_cyc = cyc;
        empty_prev = fifo_empty;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic send_bit(input logic b);
        RX = b;
        ticks(CPB);
    endtask

    // Model: a good stop bit queues the byte unless the queue already holds DEPTH bytes.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        if (stop) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ov++;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        exp = model_q.pop_front();
        dat_rd = 1'b1;
        ticks(1);
        dat_rd = 1'b0;
        chk({tag, "_valid"}, 32'(dat_valid), 32'd1);
        chk({tag, "_dat"}, 32'(dat), 32'(exp));
    endtask

    initial begin
        int start_cyc, d, lo, fe0, ov0;
        logic [7:0] b;

        ticks(4);
        chk("rst_dat", 32'(dat), 32'h00);
        chk("rst_valid", 32'(dat_valid), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_afull", 32'(fifo_afull), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        ticks(2 * CPB);

        // Single byte and its arrival latency, measured from the start edge.
        start_cyc = cyc;
        fall_cyc  = -1;
        send_frame(8'hA5, 1'b1);
        d  = fall_cyc - start_cyc;
        lo = CPB / 2 + 9 * CPB;
        chk("a5_latency_in_window", 32'(fall_cyc >= 0 && d >= lo && d <= lo + 4), 32'd1);
        pop_check("a5");
        chk("a5_empty_after_pop", 32'(fifo_empty), 32'd1);
        ticks(1);
        chk("a5_valid_drops", 32'(dat_valid), 32'd0);
        chk("a5_dat_holds", 32'(dat), 32'hA5);

        // Back-to-back frames with no idle gap.
        fe0 = fe_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        ticks(CPB);
        chk("b2b_no_ferr", 32'(fe_cnt), 32'(fe0));
        pop_check("b2b0");
        pop_check("b2b1");
        pop_check("b2b2");
        chk("b2b_empty", 32'(fifo_empty), 32'd1);

        // Framing error, then a clean frame.
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        RX = 1'b1;
        ticks(2 * CPB);
        chk("ferr_one_pulse", 32'(fe_cnt), 32'(fe0 + 1));
        chk("ferr_empty", 32'(fifo_empty), 32'd1);
        send_frame(8'h12, 1'b1);
        ticks(2);
        pop_check("after_ferr");

        // Short low glitch on the idle line.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        RX = 1'b0;
        ticks(CPB / 2 - 4);
        RX = 1'b1;
        ticks(3 * CPB);
        chk("glitch_empty", 32'(fifo_empty), 32'd1);
        chk("glitch_no_ferr", 32'(fe_cnt), 32'(fe0));
        chk("glitch_no_ovf", 32'(ov_cnt), 32'(ov0));

        // Random fill to one past capacity; read indices are mid-buffer so both wrap.
        ov0    = ov_cnt;
        exp_ov = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            ticks(2);
            chk("fill_afull", 32'(fifo_afull), 32'(model_q.size() >= AFULL));
            chk("fill_full", 32'(fifo_full), 32'(model_q.size() == DEPTH));
            chk("fill_empty", 32'(fifo_empty), 32'(model_q.size() == 0));
        end
        chk("fill_ovf_count", 32'(ov_cnt - ov0), 32'(exp_ov));
        chk("fill_model_ovf", 32'(exp_ov), 32'd1);
        while (model_q.size() > 0) begin
            pop_check("drain");
            ticks(1);
            chk("drain_afull", 32'(fifo_afull), 32'(model_q.size() >= AFULL));
        end
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        dat_rd = 1'b1;
        ticks(1);
        dat_rd = 1'b0;
        chk("pop_empty_no_valid", 32'(dat_valid), 32'd0);

        // Reset in the middle of a frame's data bits.
        send_frame(8'h99, 1'b1);
        ticks(2);
        chk("pre_rst_nonempty", 32'(fifo_empty), 32'd0);
        RX = 1'b0;
        ticks(CPB);
        RX = 1'b1;
        ticks(2 * CPB + CPB / 2);
        reset = 1'b1;
        ticks(2);
        chk("mid_rst_dat", 32'(dat), 32'h00);
        chk("mid_rst_valid", 32'(dat_valid), 32'd0);
        chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
        chk("mid_rst_afull", 32'(fifo_afull), 32'd0);
        chk("mid_rst_full", 32'(fifo_full), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        model_q.delete();
        fe0 = fe_cnt;
        ticks(2 * CPB);
        chk("post_rst_empty", 32'(fifo_empty), 32'd1);
        send_frame(8'h7E, 1'b1);
        ticks(2);
        pop_check("post_rst");
        chk("post_rst_empty_after_pop", 32'(fifo_empty), 32'd1);
        chk("post_rst_no_ferr", 32'(fe_cnt), 32'(fe0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
